// File: rtl/sata_oob_host_ctrl.sv
// Host-side SATA OOB link-initialisation controller: drives COMRESET/COMWAKE
// requests, selects D10.2 or ALIGN transmit filler and declares link up.
module sata_oob_host_ctrl #(
  parameter int unsigned RETRY_TIMEOUT = 2_000_000,
  parameter int unsigned ALIGN_TIMEOUT = 130_000,
  parameter int unsigned SYNC_COUNT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       cominit,
  input  logic       comwake,
  input  logic       oobfinish,
  input  logic       oob_done,
  input  logic       rx_align,
  input  logic       rx_prim,
  output logic       tx_comreset,
  output logic       tx_comwake,
  output logic       tx_d10,
  output logic       tx_align,
  output logic       linkup,
  output logic [2:0] state
);

  localparam int unsigned TMAX = (RETRY_TIMEOUT > ALIGN_TIMEOUT) ? RETRY_TIMEOUT : ALIGN_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned CW   = $clog2(SYNC_COUNT + 1);

  localparam logic [TW-1:0] RETRY_LAST = TW'(RETRY_TIMEOUT - 1);
  localparam logic [TW-1:0] ALIGN_LAST = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_SAT  = '1;
  localparam logic [CW-1:0] SYNC_FULL  = CW'(SYNC_COUNT);

  // Internal states are finer than the 3-bit debug code: COMWAKE/AWAIT_DONE_W
  // and SEND_ALIGN/READY each share one externally visible encoding.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COMRESET,
    ST_AWAIT_R,
    ST_WAIT_INIT,
    ST_COMWAKE,
    ST_AWAIT_W,
    ST_WAIT_WAKE,
    ST_D10,
    ST_SEND_ALIGN,
    ST_READY
  } st_e;

  st_e           st_q, st_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] sync_q, sync_d;
  logic          wake_seen_q, wake_seen_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      timer_q     <= '0;
      sync_q      <= '0;
      wake_seen_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      timer_q     <= timer_d;
      sync_q      <= sync_d;
      wake_seen_q <= wake_seen_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    sync_d      = sync_q;
    wake_seen_d = wake_seen_q;
    timer_d     = timer_q;

    case (st_q)
      ST_IDLE:     st_d = ST_COMRESET;
      ST_COMRESET: st_d = ST_AWAIT_R;
      ST_AWAIT_R: begin
        if (oob_done) st_d = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        // cominit wins over a timeout landing in the same cycle
        if (cominit)                   st_d = ST_COMWAKE;
        else if (timer_q == RETRY_LAST) st_d = ST_COMRESET;
      end
      ST_COMWAKE:  st_d = ST_AWAIT_W;
      ST_AWAIT_W: begin
        if (oob_done) st_d = ST_WAIT_WAKE;
      end
      ST_WAIT_WAKE: begin
        if (comwake) wake_seen_d = 1'b1;
        if (oobfinish && (wake_seen_q || comwake)) st_d = ST_D10;
        else if (timer_q == RETRY_LAST)           st_d = ST_COMRESET;
      end
      ST_D10: begin
        if (rx_align)                   st_d = ST_SEND_ALIGN;
        else if (timer_q == ALIGN_LAST) st_d = ST_COMRESET;
      end
      ST_SEND_ALIGN: begin
        if (rx_prim && !rx_align) begin
          sync_d = (sync_q == SYNC_FULL) ? sync_q : sync_q + CW'(1);
          if (sync_d == SYNC_FULL) st_d = ST_READY;
        end else begin
          sync_d = '0;
        end
      end
      ST_READY: begin
        if (cominit) st_d = ST_COMRESET;
      end
      default: st_d = ST_IDLE;
    endcase

    if (restart) st_d = ST_COMRESET;

    // Timer and per-state scratch restart on every state change; the timer
    // saturates in states without a timeout so it can never wrap.
    if (st_d != st_q) begin
      timer_d     = '0;
      sync_d      = '0;
      wake_seen_d = 1'b0;
    end else if (timer_q != TIMER_SAT) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_comb begin
    tx_comreset = (st_q == ST_COMRESET);
    tx_comwake  = (st_q == ST_COMWAKE);
    tx_d10      = (st_q == ST_D10);
    tx_align    = (st_q == ST_SEND_ALIGN);
    linkup      = (st_q == ST_READY);
    case (st_q)
      ST_IDLE:       state = 3'd0;
      ST_COMRESET:   state = 3'd1;
      ST_AWAIT_R:    state = 3'd2;
      ST_WAIT_INIT:  state = 3'd3;
      ST_COMWAKE:    state = 3'd4;
      ST_AWAIT_W:    state = 3'd4;
      ST_WAIT_WAKE:  state = 3'd5;
      ST_D10:        state = 3'd6;
      ST_SEND_ALIGN: state = 3'd7;
      ST_READY:      state = 3'd7;
      default:       state = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_sata_oob_host_ctrl.sv
// Bench for sata_oob_host_ctrl: directed bring-up scenarios plus randomized
// delays, checked against timing predicted from the link-init rules.
module tb_sata_oob_host_ctrl;

  localparam int RT = 1000;
  localparam int AT = 500;
  localparam int SC = 3;

  localparam int W_INIT  = 0;
  localparam int W_FIN   = 1;
  localparam int W_ALIGN = 2;
  localparam int W_DONE  = 3;
  localparam int W_WAKE  = 4;

  logic       clk;
  logic       reset;
  logic       restart, cominit, comwake, oobfinish, oob_done, rx_align, rx_prim;
  logic       tx_comreset, tx_comwake, tx_d10, tx_align, linkup;
  logic [2:0] state;

  sata_oob_host_ctrl #(
    .RETRY_TIMEOUT(RT),
    .ALIGN_TIMEOUT(AT),
    .SYNC_COUNT   (SC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .cominit    (cominit),
    .comwake    (comwake),
    .oobfinish  (oobfinish),
    .oob_done   (oob_done),
    .rx_align   (rx_align),
    .rx_prim    (rx_prim),
    .tx_comreset(tx_comreset),
    .tx_comwake (tx_comwake),
    .tx_d10     (tx_d10),
    .tx_align   (tx_align),
    .linkup     (linkup),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cr_cnt = 0;
  int cw_cnt = 0;
  int excl_cnt = 0;
  bit prim_q[$];
  bit align_q[$];

  // pulse counters and exclusivity watch, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_comreset) cr_cnt++;
    if (tx_comwake) cw_cnt++;
    if (tx_comreset && tx_comwake) excl_cnt++;
    if (tx_d10 && tx_align) excl_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      W_INIT:  cominit   = v;
      W_FIN:   oobfinish = v;
      W_ALIGN: rx_align  = v;
      W_DONE:  oob_done  = v;
      default: comwake   = v;
    endcase
  endtask

  // Called on the first cycle of a waiting state. The event input is pulsed
  // at offset drive_at; the state must leave after drive_at+1 cycles when
  // that is inside the timeout window, otherwise after exactly tmo cycles
  // back to COMRESET. A comwake pulse at offset 0 precedes oobfinish and is
  // a no-op in WAIT_INIT.
  task automatic wait_phase(input string tag, input int which, input int drive_at,
                            input int tmo, input logic [2:0] ph, input logic [2:0] adv,
                            output bit advanced);
    int k;
    int exp_k;
    logic [2:0] exp_st;
    if (drive_at < tmo) begin
      exp_k  = drive_at + 1;
      exp_st = adv;
    end else begin
      exp_k  = tmo;
      exp_st = 3'd1;
    end
    k = 0;
    while (state === ph && k < tmo + 4) begin
      if (k == 0 && (which == W_FIN || which == W_INIT)) drive(W_WAKE, 1'b1);
      if (k == drive_at) drive(which, 1'b1);
      step();
      drive(which, 1'b0);
      drive(W_WAKE, 1'b0);
      k++;
    end
    chk({tag, "_cycles"}, k, exp_k);
    chk({tag, "_state"}, 32'(state), 32'(exp_st));
    if (exp_st == 3'd1) chk({tag, "_comreset"}, 32'(tx_comreset), 32'd1);
    advanced = (exp_st == adv);
  endtask

  // From the COMRESET cycle up to the first D10 cycle.
  task automatic to_d10(input int d1, input int di, input int d2, input int df, output bit ok);
    bit a;
    ok = 1'b0;
    step();
    wait_phase("done_r", W_DONE, d1, 64, 3'd2, 3'd3, a);
    wait_phase("wait_init", W_INIT, di, RT, 3'd3, 3'd4, a);
    if (!a) return;
    chk("comwake_pulse", 32'(tx_comwake), 32'd1);
    step();
    chk("comwake_single", 32'(tx_comwake), 32'd0);
    wait_phase("done_w", W_DONE, d2, 64, 3'd4, 3'd5, a);
    wait_phase("wait_wake", W_FIN, df, RT, 3'd5, 3'd6, a);
    if (!a) return;
    chk("d10_outputs", 32'({tx_d10, tx_align}), 32'd2);
    ok = 1'b1;
  endtask

  task automatic d10_phase(input int da, output bit ok);
    wait_phase("d10", W_ALIGN, da, AT, 3'd6, 3'd7, ok);
    if (ok) chk("align_outputs", 32'({tx_d10, tx_align}), 32'd1);
    else    chk("d10_dropped", 32'(tx_d10), 32'd0);
  endtask

  // Link comes up right after the first cycle in which SC consecutive
  // prim-without-align cycles have been seen.
  task automatic sync_phase(input string tag);
    int run;
    int exp_idx;
    run = 0;
    exp_idx = -1;
    for (int i = 0; i < prim_q.size(); i++) begin
      if (prim_q[i] && !align_q[i]) run++;
      else run = 0;
      if (run == SC && exp_idx < 0) exp_idx = i;
    end
    for (int i = 0; i <= exp_idx; i++) begin
      rx_prim  = prim_q[i];
      rx_align = align_q[i];
      step();
      chk({tag, "_link"}, 32'({linkup, tx_align}), (i == exp_idx) ? 32'd2 : 32'd1);
    end
    rx_prim  = 1'b0;
    rx_align = 1'b0;
    chk({tag, "_ready"}, 32'({state, tx_d10}), 32'({3'd7, 1'b0}));
  endtask

  task automatic leave_ready(input string tag, input bit use_restart);
    if (use_restart) restart = 1'b1;
    else cominit = 1'b1;
    step();
    restart = 1'b0;
    cominit = 1'b0;
    chk(tag, 32'({linkup, state, tx_comreset}), 32'({1'b0, 3'd1, 1'b1}));
  endtask

  initial begin
    bit ok;
    bit a;
    int c0, w0;
    reset = 1'b1;
    {restart, cominit, comwake, oobfinish, oob_done, rx_align, rx_prim} = '0;
    #1 reset = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 32'({tx_comreset, tx_comwake, tx_d10, tx_align, linkup, state}), 32'd0);

    // nominal bring-up
    c0 = cr_cnt;
    w0 = cw_cnt;
    reset = 1'b1;
    step();
    chk("first_comreset", 32'({state, tx_comreset}), 32'({3'd1, 1'b1}));
    to_d10(10, 50, 5, 3, ok);
    d10_phase(99, ok);
    prim_q = '{1, 1, 1};
    align_q = '{0, 0, 0};
    sync_phase("nominal");
    chk("nominal_comresets", cr_cnt - c0, 1);
    chk("nominal_comwakes", cw_cnt - w0, 1);
    leave_ready("restart_in_ready", 1'b1);

    // ALIGN timeout
    to_d10(3, 7, 2, 4, ok);
    d10_phase(AT, ok);

    // sync interrupted by an ALIGN
    to_d10(1, 0, 0, 1, ok);
    d10_phase(20, ok);
    prim_q = '{1, 1, 0, 1, 1, 1};
    align_q = '{0, 0, 1, 0, 0, 0};
    sync_phase("sync_break");
    leave_ready("cominit_in_ready", 1'b0);

    // three COMINIT timeouts in a row
    step();
    c0 = cr_cnt;
    wait_phase("done_r", W_DONE, 5, 64, 3'd2, 3'd3, a);
    for (int r = 0; r < 3; r++) begin
      wait_phase("init_timeout", W_INIT, RT, RT, 3'd3, 3'd4, a);
      step();
      wait_phase("done_r", W_DONE, 2, 64, 3'd2, 3'd3, a);
    end
    chk("timeout_comresets", cr_cnt - c0, 3);

    // restart together with cominit and timeout expiry
    repeat (RT - 1) step();
    restart = 1'b1;
    cominit = 1'b1;
    step();
    restart = 1'b0;
    cominit = 1'b0;
    chk("restart_priority", 32'({state, tx_comreset}), 32'({3'd1, 1'b1}));

    // cominit on the last timeout cycle still wins, then reset in WAIT_WAKE
    step();
    wait_phase("done_r", W_DONE, 0, 64, 3'd2, 3'd3, a);
    wait_phase("init_at_expiry", W_INIT, RT - 1, RT, 3'd3, 3'd4, a);
    step();
    wait_phase("done_w", W_DONE, 2, 64, 3'd4, 3'd5, a);
    repeat (3) step();
    chk("in_wait_wake", 32'(state), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", 32'({tx_comreset, tx_comwake, tx_d10, tx_align, linkup, state}), 32'd0);
    c0 = cr_cnt;
    w0 = cw_cnt;
    comwake = 1'b1;
    oobfinish = 1'b1;
    repeat (4) step();
    comwake = 1'b0;
    oobfinish = 1'b0;
    chk("quiet_in_reset", cr_cnt - c0 + cw_cnt - w0, 0);
    reset = 1'b1;
    step();
    chk("reset_release", 32'({state, tx_comreset}), 32'({3'd1, 1'b1}));
    step();
    chk("after_release", 32'({state, tx_comreset}), 32'({3'd2, 1'b0}));
    repeat (3) step();
    chk("single_comreset", cr_cnt - c0, 1);
    wait_phase("done_r", W_DONE, 1, 64, 3'd2, 3'd3, a);
    restart = 1'b1;
    step();
    restart = 1'b0;

    // randomized bring-up attempts, each starting on a COMRESET cycle
    for (int t = 0; t < 8; t++) begin
      int d1, di, d2, df, da;
      d1 = $urandom_range(0, 20);
      di = ($urandom_range(0, 3) == 0) ? RT : $urandom_range(0, 200);
      d2 = $urandom_range(0, 20);
      df = ($urandom_range(0, 4) == 0) ? RT : $urandom_range(1, 200);
      da = ($urandom_range(0, 4) == 0) ? AT : $urandom_range(0, 150);
      to_d10(d1, di, d2, df, ok);
      if (!ok) continue;
      d10_phase(da, ok);
      if (!ok) continue;
      prim_q.delete();
      align_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) begin
        prim_q.push_back($urandom_range(0, 3) != 0);
        align_q.push_back($urandom_range(0, 4) == 0);
      end
      repeat (SC) begin
        prim_q.push_back(1'b1);
        align_q.push_back(1'b0);
      end
      sync_phase("rand_sync");
      leave_ready("rand_leave", $urandom_range(0, 1) == 1);
    end

    chk("output_exclusivity", excl_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
